// File: rtl/mem_arbiter_if.sv
// Request, memory and response signals shared between the requesters, the
// memory port and the arbiter. The arbiter takes the slave side.
interface mem_arbiter_if;
    logic        pf_request;
    logic [63:0] pf_addr;
    logic        ld_request;
    logic [63:0] ld_addr;
    logic        st_request;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        pf_grant;
    logic        ld_grant;
    logic        st_grant;
    logic        pf_rsp_valid;
    logic        ld_rsp_valid;
    logic [63:0] rsp_data;
    logic [63:0] rsp_addr;
    logic [4:0]  outstanding;
    logic        spurious_tag;

    modport slave (
        input  pf_request, pf_addr, ld_request, ld_addr,
        input  st_request, st_addr, st_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output pf_grant, ld_grant, st_grant,
        output pf_rsp_valid, ld_rsp_valid, rsp_data, rsp_addr,
        output outstanding, spurious_tag
    );

    modport master (
        output pf_request, pf_addr, ld_request, ld_addr,
        output st_request, st_addr, st_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  pf_grant, ld_grant, st_grant,
        input  pf_rsp_valid, ld_rsp_valid, rsp_data, rsp_addr,
        input  outstanding, spurious_tag
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between prefetch, load and store with a prefetch
// starvation guard, and steers tagged read returns back to their issuer.
module mem_arbiter #(
    parameter int NUM_TAGS     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {SEL_NONE, SEL_ST, SEL_LD, SEL_PF} sel_e;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_LOAD   = 2'd1;
    localparam logic [1:0] CMD_STORE  = 2'd2;
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [2:0]  starve_cnt_reg;
    logic [4:0]  outstanding_reg;
    logic        spurious_reg;
    logic        valid_reg    [0:NUM_TAGS];
    logic        owner_ld_reg [0:NUM_TAGS];
    logic [63:0] addr_reg     [0:NUM_TAGS];

    sel_e sel;
    logic accept;
    logic resp_in_range;
    logic tag_in_range;
    logic load_write;
    logic ret_hit;
    logic ret_miss;

    assign accept        = (bus.mem2proc_response != 4'd0);
    assign resp_in_range = (int'(bus.mem2proc_response) <= NUM_TAGS);
    assign tag_in_range  = (bus.mem2proc_tag != 4'd0) && (int'(bus.mem2proc_tag) <= NUM_TAGS);
    assign load_write    = accept && resp_in_range && (sel == SEL_LD || sel == SEL_PF);
    assign ret_hit       = tag_in_range && valid_reg[bus.mem2proc_tag];
    assign ret_miss      = (bus.mem2proc_tag != 4'd0) && !ret_hit;

    // A prefetcher denied for STARVE_LIMIT cycles jumps ahead of store and load.
    always_comb begin
        sel = SEL_NONE;
        if (bus.pf_request && starve_cnt_reg == STARVE_MAX) sel = SEL_PF;
        else if (bus.st_request)                            sel = SEL_ST;
        else if (bus.ld_request)                            sel = SEL_LD;
        else if (bus.pf_request)                            sel = SEL_PF;
    end

    always_comb begin
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.pf_grant         = 1'b0;
        bus.ld_grant         = 1'b0;
        bus.st_grant         = 1'b0;
        case (sel)
            SEL_ST: begin
                bus.proc2mem_command = CMD_STORE;
                bus.proc2mem_addr    = bus.st_addr;
                bus.proc2mem_data    = bus.st_data;
                bus.st_grant         = accept;
            end
            SEL_LD: begin
                bus.proc2mem_command = CMD_LOAD;
                bus.proc2mem_addr    = bus.ld_addr;
                bus.ld_grant         = accept;
            end
            SEL_PF: begin
                bus.proc2mem_command = CMD_LOAD;
                bus.proc2mem_addr    = bus.pf_addr;
                bus.pf_grant         = accept;
            end
            default: ;
        endcase
    end

    assign bus.pf_rsp_valid = ret_hit && !owner_ld_reg[bus.mem2proc_tag];
    assign bus.ld_rsp_valid = ret_hit &&  owner_ld_reg[bus.mem2proc_tag];
    assign bus.rsp_addr     = ret_hit ? addr_reg[bus.mem2proc_tag] : 64'd0;
    assign bus.rsp_data     = bus.mem2proc_data;
    assign bus.outstanding  = outstanding_reg;
    assign bus.spurious_tag = spurious_reg;

    // A write to the tag being returned takes precedence, so a tag can be
    // retired and reissued in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NUM_TAGS; i++) begin
                valid_reg[i]    <= 1'b0;
                owner_ld_reg[i] <= 1'b0;
                addr_reg[i]     <= '0;
            end
        end else begin
            for (int i = 1; i <= NUM_TAGS; i++) begin
                if (load_write && int'(bus.mem2proc_response) == i) begin
                    valid_reg[i]    <= 1'b1;
                    owner_ld_reg[i] <= (sel == SEL_LD);
                    addr_reg[i]     <= bus.proc2mem_addr;
                end else if (ret_hit && int'(bus.mem2proc_tag) == i) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_reg  <= '0;
            outstanding_reg <= '0;
            spurious_reg    <= 1'b0;
        end else begin
            if (bus.pf_request && !bus.pf_grant) begin
                if (starve_cnt_reg != STARVE_MAX) starve_cnt_reg <= starve_cnt_reg + 3'd1;
            end else begin
                starve_cnt_reg <= '0;
            end

            if (load_write && !ret_hit)      outstanding_reg <= outstanding_reg + 5'd1;
            else if (!load_write && ret_hit) outstanding_reg <= outstanding_reg - 5'd1;

            if (ret_miss) spurious_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a tag-map reference model
// fills a per-cycle expectation queue that a negedge monitor drains.
module tb_mem_arbiter;
    localparam int NUM_TAGS     = 15;
    localparam int STARVE_LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if bus();

    mem_arbiter #(.NUM_TAGS(NUM_TAGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] data;
        logic        pf_g;
        logic        ld_g;
        logic        st_g;
        logic        pf_v;
        logic        ld_v;
        logic [63:0] raddr;
        logic [63:0] rdata;
        logic [4:0]  outst;
        logic        spur;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: outstanding reads keyed by tag, starvation count, sticky flag.
    bit          m_owner_ld[int];
    logic [63:0] m_addr[int];
    int          m_starve = 0;
    bit          m_spur   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic model_reset();
        m_owner_ld.delete();
        m_addr.delete();
        m_starve = 0;
        m_spur   = 1'b0;
    endtask

    task automatic set_inputs(input bit pf, input logic [63:0] pa, input bit ld, input logic [63:0] la,
                              input bit st, input logic [63:0] sa, input logic [63:0] sd,
                              input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rd);
        bus.pf_request        = pf;
        bus.pf_addr           = pa;
        bus.ld_request        = ld;
        bus.ld_addr           = la;
        bus.st_request        = st;
        bus.st_addr           = sa;
        bus.st_data           = sd;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = tag;
        bus.mem2proc_data     = rd;
    endtask

    // One clock of stimulus: apply inputs, queue what the DUT should show, advance the model.
    task automatic drive(input bit pf, input logic [63:0] pa, input bit ld, input logic [63:0] la,
                         input bit st, input logic [63:0] sa, input logic [63:0] sd,
                         input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rd);
        exp_t e;
        int   win;
        int   t;
        int   r;
        @(posedge clock);
        #1;
        set_inputs(pf, pa, ld, la, st, sa, sd, resp, tag, rd);
        t = int'(tag);
        r = int'(resp);
        win = 0;
        if (pf && m_starve >= STARVE_LIMIT) win = 3;
        else if (st)                        win = 1;
        else if (ld)                        win = 2;
        else if (pf)                        win = 3;
        e.cmd   = (win == 0) ? 2'd0 : (win == 1) ? 2'd2 : 2'd1;
        e.addr  = (win == 1) ? sa : (win == 2) ? la : (win == 3) ? pa : 64'd0;
        e.data  = (win == 1) ? sd : 64'd0;
        e.st_g  = (win == 1) && (r != 0);
        e.ld_g  = (win == 2) && (r != 0);
        e.pf_g  = (win == 3) && (r != 0);
        e.pf_v  = 1'b0;
        e.ld_v  = 1'b0;
        e.raddr = 64'd0;
        e.rdata = rd;
        e.outst = 5'(m_owner_ld.num());
        e.spur  = m_spur;
        if (t != 0 && m_owner_ld.exists(t)) begin
            e.ld_v  = m_owner_ld[t];
            e.pf_v  = !m_owner_ld[t];
            e.raddr = m_addr[t];
        end
        exp_q.push_back(e);

        if (t != 0) begin
            if (m_owner_ld.exists(t)) begin
                m_owner_ld.delete(t);
                m_addr.delete(t);
            end else begin
                m_spur = 1'b1;
            end
        end
        if (r != 0 && (win == 2 || win == 3)) begin
            m_owner_ld[r] = (win == 2);
            m_addr[r]     = e.addr;
        end
        if (pf && !(win == 3 && r != 0)) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
        else                             m_starve = 0;
    endtask

    task automatic idle(input logic [3:0] tag, input logic [63:0] rd);
        drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd0, tag, rd);
    endtask

    // Reset asserted between clock edges; its effect must be visible at once.
    task automatic async_reset();
        @(posedge clock);
        #3;
        set_inputs(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        reset = 1'b1;
        #1;
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_spurious", 64'(bus.spurious_tag), 64'd0);
        check("rst_command", 64'(bus.proc2mem_command), 64'd0);
        check("rst_addr", bus.proc2mem_addr, 64'd0);
        check("rst_grants", 64'({bus.pf_grant, bus.ld_grant, bus.st_grant}), 64'd0);
        check("rst_rsp_valid", 64'({bus.pf_rsp_valid, bus.ld_rsp_valid}), 64'd0);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic random_phase(input int cycles);
        int          keys[$];
        int          free[$];
        int          rr;
        logic [3:0]  tag;
        logic [3:0]  resp;
        logic [63:0] pa;
        logic [63:0] la;
        logic [63:0] sa;
        logic [63:0] sd;
        logic [63:0] rd;
        for (int k = 0; k < cycles; k++) begin
            keys.delete();
            free.delete();
            foreach (m_owner_ld[key]) keys.push_back(key);
            tag = 4'd0;
            rr  = int'($urandom_range(0, 99));
            if (keys.size() > 0 && rr < 45) begin
                tag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
            end else if (rr >= 97 && keys.size() < NUM_TAGS) begin
                for (int x = 1; x <= NUM_TAGS; x++) if (!m_owner_ld.exists(x)) free.push_back(x);
                tag = 4'(free[$urandom_range(0, free.size() - 1)]);
                free.delete();
            end
            for (int x = 1; x <= NUM_TAGS; x++)
                if (!m_owner_ld.exists(x) || x == int'(tag)) free.push_back(x);
            resp = 4'd0;
            if (free.size() > 0 && $urandom_range(0, 9) < 8)
                resp = 4'(free[$urandom_range(0, free.size() - 1)]);
            pa = {$urandom, $urandom} & ~64'h7;
            la = {$urandom, $urandom};
            sa = {$urandom, $urandom};
            sd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            drive($urandom_range(0, 9) < 6, pa, $urandom_range(0, 9) < 4, la,
                  $urandom_range(0, 9) < 3, sa, sd, resp, tag, rd);
        end
    endtask

    // Monitor: every queued cycle is compared against what the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("t=%0t cmd=%0d addr=%h g(pf,ld,st)=%b%b%b v(pf,ld)=%b%b raddr=%h out=%0d spur=%b",
                         $time, bus.proc2mem_command, bus.proc2mem_addr, bus.pf_grant, bus.ld_grant,
                         bus.st_grant, bus.pf_rsp_valid, bus.ld_rsp_valid, bus.rsp_addr,
                         bus.outstanding, bus.spurious_tag);
                check("command", 64'(bus.proc2mem_command), 64'(e.cmd));
                check("mem_addr", bus.proc2mem_addr, e.addr);
                check("mem_data", bus.proc2mem_data, e.data);
                check("pf_grant", 64'(bus.pf_grant), 64'(e.pf_g));
                check("ld_grant", 64'(bus.ld_grant), 64'(e.ld_g));
                check("st_grant", 64'(bus.st_grant), 64'(e.st_g));
                check("pf_rsp_valid", 64'(bus.pf_rsp_valid), 64'(e.pf_v));
                check("ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'(e.ld_v));
                check("outstanding", 64'(bus.outstanding), 64'(e.outst));
                check("spurious_tag", 64'(bus.spurious_tag), 64'(e.spur));
                if (e.pf_v || e.ld_v) begin
                    check("rsp_addr", bus.rsp_addr, e.raddr);
                    check("rsp_data", bus.rsp_data, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_inputs(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        #2;
        reset = 1'b1;
        #10;
        check("init_outstanding", 64'(bus.outstanding), 64'd0);
        check("init_spurious", 64'(bus.spurious_tag), 64'd0);
        check("init_command", 64'(bus.proc2mem_command), 64'd0);
        #5;
        reset = 1'b0;
        model_reset();
        idle(4'd0, 64'd0);

        // single prefetch and its return
        drive(1'b1, 64'h40, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
        idle(4'd3, 64'hDEAD);
        idle(4'd0, 64'd0);

        // contention, then prefetch promotion after four denied cycles
        drive(1'b1, 64'h48, 1'b1, 64'h1000, 1'b1, 64'h2000, 64'h11, 4'd9, 4'd0, 64'd0);
        drive(1'b1, 64'h48, 1'b1, 64'h1000, 1'b0, 64'd0, 64'd0, 4'd1, 4'd0, 64'd0);
        drive(1'b1, 64'h48, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd2, 4'd0, 64'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 64'h50, 1'b1, 64'h1008, 1'b1, 64'h2008, 64'h22, 4'd9, 4'd0, 64'd0);
        drive(1'b1, 64'h50, 1'b1, 64'h1008, 1'b1, 64'h2008, 64'h22, 4'd4, 4'd0, 64'd0);
        drive(1'b1, 64'h58, 1'b1, 64'h1008, 1'b1, 64'h2008, 64'h22, 4'd9, 4'd0, 64'd0);
        idle(4'd1, 64'hA1);
        idle(4'd2, 64'hA2);
        idle(4'd4, 64'hA4);

        // out-of-order returns
        drive(1'b0, 64'd0, 1'b1, 64'h100, 1'b0, 64'd0, 64'd0, 4'd1, 4'd0, 64'd0);
        drive(1'b1, 64'h108, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd2, 4'd0, 64'd0);
        idle(4'd2, 64'hB2);
        idle(4'd1, 64'hB1);

        // tag 5 retired and reissued in one cycle
        drive(1'b0, 64'd0, 1'b1, 64'h200, 1'b0, 64'd0, 64'd0, 4'd5, 4'd0, 64'd0);
        drive(1'b1, 64'h208, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 4'd5, 4'd5, 64'hC5);
        idle(4'd0, 64'd0);
        idle(4'd5, 64'hD5);

        // memory reject, then a spurious return
        drive(1'b0, 64'd0, 1'b1, 64'h300, 1'b0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        idle(4'd0, 64'd0);
        idle(4'd7, 64'hE7);
        idle(4'd0, 64'd0);
        idle(4'd0, 64'd0);

        // reset with three reads in flight, then a stale return
        drive(1'b0, 64'd0, 1'b1, 64'h400, 1'b0, 64'd0, 64'd0, 4'd1, 4'd0, 64'd0);
        drive(1'b0, 64'd0, 1'b1, 64'h408, 1'b0, 64'd0, 64'd0, 4'd2, 4'd0, 64'd0);
        drive(1'b0, 64'd0, 1'b1, 64'h410, 1'b0, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
        idle(4'd0, 64'd0);
        async_reset();
        idle(4'd2, 64'hF2);
        idle(4'd0, 64'd0);
        idle(4'd0, 64'd0);

        async_reset();
        random_phase(400);
        idle(4'd0, 64'd0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
